crop_filter: RTL and testbench
==============================

Name: crop_filter

Overview:
Upstream neighbour of the normalising stage. It accepts a full IN_ROWS x IN_COLS 8-bit image on an AXI-Stream slave and forwards only the OUT_ROWS x OUT_COLS window, in raster order, that starts at a runtime (row, col) offset. While cropping it tracks the maximum pixel value inside the window. On frame completion it publishes that value as norm_denominator and pulses ap_done, which drives cf_ap_done downstream. Its m_axis feeds an external axis_fifo with depth >= OUT_ROWS*OUT_COLS, because the next stage holds off reading until ap_done.

Parameters:
IN_ROWS, 64, input image height
IN_COLS, 64, input image width
OUT_ROWS, 10, crop window height
OUT_COLS, 10, crop window width

Ports:
clk  in  1  clock
s_axis_resetn  in  1  asynchronous active-low reset
ap_start  in  1  start one frame; sampled only in IDLE
ap_ready  out  1  high in IDLE
ap_done  out  1  one-cycle pulse, frame complete
ap_idle  out  1  high in IDLE
crop_row_start  in  $clog2(IN_ROWS)  window top row, latched on ap_start
crop_col_start  in  $clog2(IN_COLS)  window left column, latched on ap_start
s_axis_tvalid  in  1  input pixel valid
s_axis_tready  out  1  input pixel accepted
s_axis_tdata  in  8  input pixel
s_axis_tlast  in  1  last pixel of the input frame
m_axis_tvalid  out  1  cropped pixel valid
m_axis_tready  in  1  downstream ready
m_axis_tdata  out  8  cropped pixel
norm_denominator  out  8  window maximum; 1 if the maximum is 0
frame_err  out  1  sticky flag: tlast position mismatch

Behaviour:
- Reset (asynchronous, s_axis_resetn=0) sets:
  - state to IDLE;
  - all counters to 0;
  - m_axis_tvalid=0, m_axis_tdata=0, ap_done=0;
  - norm_denominator=1, frame_err=0.
- State machine IDLE -> CROP -> FLUSH -> IDLE.
- IDLE:
  - ap_ready=1, ap_idle=1, s_axis_tready=0.
  - On ap_start: latch the offsets, clear row/col counters and max_r, then go to CROP.
- Offset clamp at latch: if crop_row_start+OUT_ROWS > IN_ROWS, latch IN_ROWS-OUT_ROWS. The same rule applies to columns.
- in_win = (row in [r0, r0+OUT_ROWS-1]) and (col in [c0, c0+OUT_COLS-1]).
- CROP, input side:
  - s_axis_tready = !in_win || !m_axis_tvalid || m_axis_tready.
  - Out-of-window pixels are consumed and dropped at one per cycle.
- Output register: single stage, so latency is one cycle from input handshake to m_axis_tvalid.
  - An in-window handshake loads m_axis_tdata and sets m_axis_tvalid.
  - An output handshake with no new load clears m_axis_tvalid.
  - A simultaneous output handshake and new load keeps m_axis_tvalid=1 with the new data, giving one pixel per cycle of throughput.
  - m_axis_tdata is held stable while tvalid=1 and tready=0.
- Max tracking: on each in-window handshake, max_r <= max(max_r, s_axis_tdata).
- Counters advance on every input handshake:
  - col wraps at IN_COLS-1 to 0 and increments row.
- Last pixel of the frame is row=IN_ROWS-1, col=IN_COLS-1:
  - On its handshake, go to FLUSH.
  - If s_axis_tlast=0 on this handshake, set frame_err.
  - If s_axis_tlast=1 on any earlier handshake, set frame_err, but keep counting; no early exit.
- FLUSH:
  - s_axis_tready=0.
  - Once m_axis_tvalid=0 (i.e. the last output has been handshaked), drive ap_done=1 for one cycle, update norm_denominator, and return to IDLE.
  - norm_denominator = (max_r==0) ? 1 : max_r. It changes only in this cycle.
- ap_start outside IDLE is ignored.
- frame_err clears only on reset or on an accepted ap_start.
- Reset mid-frame aborts immediately. Partially forwarded pixels are not retracted, and the downstream FIFO is reset by the same signal.

Decomposition:
- Package crop_pkg:
  - state enum {IDLE, CROP, FLUSH};
  - PIX_W=8;
  - helper function clamp_start(start, in_dim, out_dim).
- One sub-module, crop_out_reg: the single-stage AXIS output register (tvalid/tdata/tready with the load/unload rules above).
- Counters, window compare, max tracking and the FSM stay in crop_filter.

Test Plan:
- 8x8 frame of ramp pixels (value=row*8+col), 3x3 window, offset (2,2), tready=1 -> outputs 18,19,20,26,27,28,34,35,36 in order. norm_denominator=36. ap_done pulses once, one cycle after the last output handshake.
- Same frame with m_axis_tready toggled 1-0-0-1 -> output data and order identical, tdata stable while stalled, no dropped or duplicated pixels, exactly 9 output handshakes.
- Offset (7,7) with a 3x3 window on 8x8 -> clamped to (5,5). Outputs 45,46,47,53,54,55,61,62,63.
- All-zero frame -> 9 zero outputs, norm_denominator=1.
- tlast asserted at pixel 62 and deasserted at pixel 63 -> frame_err=1, frame still completes, ap_done pulses. The next ap_start clears frame_err.
- s_axis_resetn dropped for 2 cycles mid-window -> m_axis_tvalid=0, ap_ready=1, norm_denominator=1 asynchronously. A following clean frame gives correct outputs.

Source files
------------

// File: rtl/crop_filter_pkg.sv
// crop_pkg: shared types and helpers for the crop filter.
package crop_pkg;
  localparam int PIX_W = 8;
  typedef enum logic [1:0] {IDLE, CROP, FLUSH} state_t;
  function automatic int clamp_start(int start, int in_dim, int out_dim);
    return (start + out_dim > in_dim) ? in_dim - out_dim : start;
  endfunction
endpackage

// File: rtl/crop_filter_if.sv
// crop_filter_if: AXI-Stream pixel channel.
interface crop_filter_if;
  import crop_pkg::*;
  logic tvalid;
  logic tready;
  logic tlast;
  logic [PIX_W-1:0] tdata;
  modport master(output tvalid, tdata, input tready);
  modport slave(input tvalid, tdata, tlast, output tready);
endinterface

// File: rtl/crop_filter_out_reg.sv
// crop_out_reg: single-stage AXIS output register with full throughput.
module crop_out_reg
  import crop_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [PIX_W-1:0] din,
  output logic             can_load,
  crop_filter_if.master    m
);
  assign can_load = !m.tvalid || m.tready;
  // load is only asserted when can_load, so tdata never changes while stalled
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m.tvalid <= 1'b0;
      m.tdata  <= '0;
    end else begin
      if (load) m.tdata <= din;
      m.tvalid <= load || (m.tvalid && !m.tready);
    end
endmodule

// File: rtl/crop_filter.sv
// crop_filter: forwards a runtime-offset window of a raster frame and reports its maximum.
module crop_filter
  import crop_pkg::*;
#(
  parameter int IN_ROWS  = 64,
  parameter int IN_COLS  = 64,
  parameter int OUT_ROWS = 10,
  parameter int OUT_COLS = 10
) (
  input  logic                       clk,
  input  logic                       s_axis_resetn,
  input  logic                       ap_start,
  output logic                       ap_ready,
  output logic                       ap_done,
  output logic                       ap_idle,
  input  logic [$clog2(IN_ROWS)-1:0] crop_row_start,
  input  logic [$clog2(IN_COLS)-1:0] crop_col_start,
  crop_filter_if.slave               s_axis,
  crop_filter_if.master              m_axis,
  output logic [PIX_W-1:0]           norm_denominator,
  output logic                       frame_err
);
  localparam int RW = $clog2(IN_ROWS);
  localparam int CW = $clog2(IN_COLS);
  localparam logic [RW:0] R_SPAN = (RW+1)'(OUT_ROWS);
  localparam logic [CW:0] C_SPAN = (CW+1)'(OUT_COLS);
  localparam logic [RW-1:0] R_LAST = RW'(IN_ROWS - 1);
  localparam logic [CW-1:0] C_LAST = CW'(IN_COLS - 1);
  state_t state, next;
  logic [RW-1:0] row, r0;
  logic [CW-1:0] col, c0;
  logic [PIX_W-1:0] max_r;
  logic in_win, s_hs, last_pix, can_load, start;
  // one extra bit keeps start+span from wrapping when the window touches the edge
  assign in_win = row >= r0 && {1'b0, row} < {1'b0, r0} + R_SPAN &&
                  col >= c0 && {1'b0, col} < {1'b0, c0} + C_SPAN;
  assign s_axis.tready = state == CROP && (!in_win || can_load);
  assign s_hs = s_axis.tvalid && s_axis.tready;
  assign last_pix = row == R_LAST && col == C_LAST;
  assign start = state == IDLE && ap_start;
  assign ap_ready = state == IDLE;
  assign ap_idle = state == IDLE;
  assign ap_done = state == FLUSH && !m_axis.tvalid;
  always_ff @(posedge clk or negedge s_axis_resetn)
    if (!s_axis_resetn) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    if (start) next = CROP;
    if (state == CROP && s_hs && last_pix) next = FLUSH;
    if (ap_done) next = IDLE;
  end
  always_ff @(posedge clk or negedge s_axis_resetn)
    if (!s_axis_resetn) begin
      row <= '0;
      col <= '0;
      r0 <= '0;
      c0 <= '0;
      max_r <= '0;
      norm_denominator <= PIX_W'(1);
      frame_err <= 1'b0;
    end else begin
      if (start) begin
        r0 <= RW'(clamp_start(int'(crop_row_start), IN_ROWS, OUT_ROWS));
        c0 <= CW'(clamp_start(int'(crop_col_start), IN_COLS, OUT_COLS));
        row <= '0;
        col <= '0;
        max_r <= '0;
        frame_err <= 1'b0;
      end
      if (s_hs) begin
        col <= col == C_LAST ? '0 : col + CW'(1);
        if (col == C_LAST) row <= last_pix ? '0 : row + RW'(1);
        if (in_win && s_axis.tdata > max_r) max_r <= s_axis.tdata;
        if (last_pix ? !s_axis.tlast : s_axis.tlast) frame_err <= 1'b1;
      end
      if (ap_done) norm_denominator <= max_r == '0 ? PIX_W'(1) : max_r;
    end
  crop_out_reg u_out (
    .clk     (clk),
    .rst_n   (s_axis_resetn),
    .load    (s_hs && in_win),
    .din     (s_axis.tdata),
    .can_load(can_load),
    .m       (m_axis)
  );
endmodule

// File: tb/tb_crop_filter.sv
// tb_crop_filter: scoreboard bench for crop_filter on an 8x8 frame with a 3x3 window.
module tb_crop_filter;
  import crop_pkg::*;
  localparam int IR = 8, IC = 8, OR = 3, OC = 3;
  logic clk = 0, rst_n = 1, ap_start = 0;
  logic ap_ready, ap_done, ap_idle, frame_err;
  logic [2:0] crop_r = 0, crop_c = 0;
  logic [7:0] norm;
  int n_chk = 0, n_fail = 0;
  logic [7:0] exp_q[$];
  int out_cnt = 0, done_cnt = 0, cyc = 0, last_hs_cyc = 0, done_cyc = 0;
  logic pv = 0, pr = 0;
  logic [7:0] pd = 0;
  crop_filter_if s_if ();
  crop_filter_if m_if ();
  crop_filter #(.IN_ROWS(IR), .IN_COLS(IC), .OUT_ROWS(OR), .OUT_COLS(OC)) dut (
    .clk(clk), .s_axis_resetn(rst_n), .ap_start(ap_start), .ap_ready(ap_ready),
    .ap_done(ap_done), .ap_idle(ap_idle), .crop_row_start(crop_r), .crop_col_start(crop_c),
    .s_axis(s_if.slave), .m_axis(m_if.master), .norm_denominator(norm), .frame_err(frame_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  always @(negedge clk) begin
    if (rst_n) begin
      if (pv && !pr) begin
        n_chk++;
        if (m_if.tvalid !== 1'b1 || m_if.tdata !== pd) begin
          n_fail++;
          $display("FAIL stall_hold: tvalid=%b tdata=%0d required tvalid=1 tdata=%0d", m_if.tvalid, m_if.tdata, pd);
        end
      end
      if (m_if.tvalid && m_if.tready) begin
        out_cnt++;
        last_hs_cyc = cyc;
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL out_extra: got %0d required no output", m_if.tdata);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (m_if.tdata !== e) begin
            n_fail++;
            $display("FAIL out_data: got %0d required %0d", m_if.tdata, e);
          end
        end
      end
      if (ap_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
    pv = m_if.tvalid;
    pr = m_if.tready;
    pd = m_if.tdata;
  end

  function automatic int mclamp(int s, int span, int dim);
    return (s + span > dim) ? dim - span : s;
  endfunction

  task automatic start_frame(input int r, input int c);
    out_cnt = 0;
    done_cnt = 0;
    ap_start = 1;
    crop_r = 3'(r);
    crop_c = 3'(c);
    @(posedge clk); #1;
    ap_start = 0;
  endtask

  task automatic drive_pixels(input int first, input int last, input int r0, input int c0,
                              input bit bad_tlast, input bit zero);
    for (int p = first; p <= last; p++) begin
      int r, c, t;
      bit hs;
      r = p / IC;
      c = p % IC;
      s_if.tvalid = 1;
      s_if.tdata = zero ? 8'd0 : 8'(p);
      s_if.tlast = bad_tlast ? (p == 62) : (p == 63);
      if (r >= r0 && r < r0 + OR && c >= c0 && c < c0 + OC) exp_q.push_back(s_if.tdata);
      t = 0;
      hs = 0;
      do begin
        @(negedge clk);
        hs = s_if.tready;
        @(posedge clk); #1;
        t++;
      end while (!hs && t < 100);
      if (!hs) begin
        n_chk++;
        n_fail++;
        $display("FAIL in_timeout: pixel %0d not accepted, required accept within 100 cycles", p);
        break;
      end
    end
    s_if.tvalid = 0;
    s_if.tlast = 0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (done_cnt == 0 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (done_cnt == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL done_timeout: ap_done not seen, required within 50 cycles");
    end
  endtask

  task automatic test_reset();
    s_if.tvalid = 0;
    s_if.tlast = 0;
    s_if.tdata = 0;
    m_if.tready = 1;
    #1 rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if ({ap_idle, ap_ready, ap_done, m_if.tvalid, s_if.tready, frame_err} !== 6'b110000 ||
        m_if.tdata !== 8'd0 || norm !== 8'd1) begin
      n_fail++;
      $display("FAIL reset: idle/ready/done/mvalid/sready/err=%b tdata=%0d norm=%0d required 110000 0 1",
               {ap_idle, ap_ready, ap_done, m_if.tvalid, s_if.tready, frame_err}, m_if.tdata, norm);
    end
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_ramp();
    start_frame(2, 2);
    ap_start = 1;
    crop_r = 0;
    crop_c = 0;
    drive_pixels(0, 63, 2, 2, 0, 0);
    ap_start = 0;
    wait_done();
    n_chk++;
    if (norm !== 8'd36) begin n_fail++; $display("FAIL ramp_norm: got %0d required 36", norm); end
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (out_cnt !== 9 || exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL ramp_count: outputs %0d left %0d required 9 0", out_cnt, exp_q.size());
    end
    n_chk++;
    if (done_cnt !== 1 || done_cyc <= last_hs_cyc) begin
      n_fail++;
      $display("FAIL ramp_done: pulses %0d at %0d last out %0d required 1 pulse after last out", done_cnt, done_cyc, last_hs_cyc);
    end
    n_chk++;
    if (frame_err !== 1'b0 || ap_idle !== 1'b1) begin
      n_fail++;
      $display("FAIL ramp_state: err=%b idle=%b required 0 1", frame_err, ap_idle);
    end
  endtask

  task automatic test_stall();
    bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    bit stop = 0;
    start_frame(2, 2);
    fork
      begin
        drive_pixels(0, 63, 2, 2, 0, 0);
        wait_done();
        stop = 1;
      end
      begin
        int ph = 0;
        while (!stop) begin
          m_if.tready = pat[ph % 4];
          ph++;
          @(posedge clk); #1;
        end
      end
    join
    m_if.tready = 1;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (out_cnt !== 9 || exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL stall_count: outputs %0d left %0d required 9 0", out_cnt, exp_q.size());
    end
    n_chk++;
    if (norm !== 8'd36 || done_cnt !== 1) begin
      n_fail++;
      $display("FAIL stall_done: norm %0d pulses %0d required 36 1", norm, done_cnt);
    end
  endtask

  task automatic test_clamp();
    start_frame(7, 7);
    drive_pixels(0, 63, mclamp(7, OR, IR), mclamp(7, OC, IC), 0, 0);
    wait_done();
    n_chk++;
    if (norm !== 8'd63) begin n_fail++; $display("FAIL clamp_norm: got %0d required 63", norm); end
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (out_cnt !== 9 || exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL clamp_count: outputs %0d left %0d required 9 0", out_cnt, exp_q.size());
    end
    n_chk++;
    if (done_cnt !== 1 || done_cyc !== last_hs_cyc + 1) begin
      n_fail++;
      $display("FAIL clamp_done: pulses %0d at %0d required 1 at %0d", done_cnt, done_cyc, last_hs_cyc + 1);
    end
  endtask

  task automatic test_zero();
    start_frame(2, 2);
    drive_pixels(0, 63, 2, 2, 0, 1);
    wait_done();
    n_chk++;
    if (norm !== 8'd1) begin n_fail++; $display("FAIL zero_norm: got %0d required 1", norm); end
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (out_cnt !== 9 || exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL zero_count: outputs %0d left %0d required 9 0", out_cnt, exp_q.size());
    end
  endtask

  task automatic test_tlast();
    start_frame(2, 2);
    drive_pixels(0, 63, 2, 2, 1, 0);
    wait_done();
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (frame_err !== 1'b1 || done_cnt !== 1 || out_cnt !== 9 || norm !== 8'd36) begin
      n_fail++;
      $display("FAIL tlast_err: err=%b pulses %0d outputs %0d norm %0d required 1 1 9 36", frame_err, done_cnt, out_cnt, norm);
    end
    start_frame(2, 2);
    n_chk++;
    if (frame_err !== 1'b0) begin n_fail++; $display("FAIL tlast_clear: err=%b required 0", frame_err); end
    drive_pixels(0, 63, 2, 2, 0, 0);
    wait_done();
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (frame_err !== 1'b0 || out_cnt !== 9) begin
      n_fail++;
      $display("FAIL tlast_clean: err=%b outputs %0d required 0 9", frame_err, out_cnt);
    end
  endtask

  task automatic test_reset_mid();
    start_frame(2, 2);
    drive_pixels(0, 27, 2, 2, 0, 0);
    #1 rst_n = 0;
    #1;
    n_chk++;
    if (m_if.tvalid !== 1'b0 || ap_ready !== 1'b1 || norm !== 8'd1) begin
      n_fail++;
      $display("FAIL reset_mid: mvalid=%b ready=%b norm=%0d required 0 1 1", m_if.tvalid, ap_ready, norm);
    end
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk); #1;
    start_frame(2, 2);
    drive_pixels(0, 63, 2, 2, 0, 0);
    wait_done();
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (out_cnt !== 9 || exp_q.size() !== 0 || norm !== 8'd36 || frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_recover: outputs %0d left %0d norm %0d err %b required 9 0 36 0", out_cnt, exp_q.size(), norm, frame_err);
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_stall();
    test_clamp();
    test_zero();
    test_tlast();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
